// File: rtl/spwm_ctrl.sv
// spwm_ctrl: SPWM carrier/sine-index sequencer with sine-period start/stop granularity.
// Define SPWM_CTRL_COMPLEMENT_EN to add the dead-time complementary output pwm_n.
module spwm_ctrl #(
    parameter int unsigned CW        = 8,
    parameter int unsigned CAR_MAX   = 255,
    parameter int unsigned IW        = 6,
    parameter int unsigned N_SAMPLES = 64,
    parameter int unsigned PW        = 8,
    parameter int unsigned DEAD      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [PW-1:0] presc,
    input  logic [CW-1:0] sample,
    output logic [IW-1:0] idx,
    output logic [CW-1:0] carrier,
    output logic          pwm_out,
`ifdef SPWM_CTRL_COMPLEMENT_EN
    output logic          pwm_n,
`endif
    output logic          busy,
    output logic          period_done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP_PEND} state_t;

    localparam logic [CW-1:0] CAR_TOP  = CW'(CAR_MAX);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_SAMPLES - 1);

    if (N_SAMPLES == 0 || N_SAMPLES > (1 << IW) || CAR_MAX >= (1 << CW) || DEAD >= (1 << 16))
    begin : g_bad_params
        $error("spwm_ctrl: parameter out of range");
    end

    state_t        r_state, w_next;
    logic [PW-1:0] r_presc_lat, r_presc_cnt;
    logic [CW-1:0] r_carrier, r_duty;
    logic [IW-1:0] r_idx, w_idx_inc;
    logic          r_raw, r_period_done;
    logic          w_active, w_start_edge, w_tick, w_wrap, w_period_end;

    assign w_active     = (r_state != S_IDLE);
    assign w_start_edge = (r_state == S_IDLE) && start;
    assign w_tick       = w_active && (r_presc_cnt == r_presc_lat);
    assign w_wrap       = w_tick && (r_carrier == CAR_TOP);
    // idx already points at the next sample, so idx==0 marks the last sample's period
    assign w_period_end = w_wrap && (r_idx == '0);
    assign w_idx_inc    = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (start)        w_next = S_RUN;
            S_RUN:       if (stop)         w_next = S_STOP_PEND;
            S_STOP_PEND: if (w_period_end) w_next = S_IDLE;
            default:                       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc_lat   <= '0;
            r_presc_cnt   <= '0;
            r_carrier     <= '0;
            r_duty        <= '0;
            r_idx         <= '0;
            r_raw         <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_period_done <= w_period_end;
            if (w_start_edge) begin
                r_presc_lat <= presc;
                r_presc_cnt <= '0;
                r_carrier   <= '0;
                r_duty      <= sample;
                r_idx       <= w_idx_inc;
                r_raw       <= 1'b0;
            end else if ((r_state == S_STOP_PEND) && w_period_end) begin
                r_presc_cnt <= '0;
                r_carrier   <= '0;
                r_duty      <= '0;
                r_idx       <= '0;
                r_raw       <= 1'b0;
            end else if (w_active) begin
                r_raw       <= (r_carrier < r_duty);
                r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PW'(1);
                if (w_tick) r_carrier <= w_wrap ? '0 : r_carrier + CW'(1);
                if (w_wrap) begin
                    r_duty <= sample;
                    r_idx  <= w_idx_inc;
                end
                if (w_period_end) r_presc_lat <= presc;
            end
        end
    end

    assign idx         = r_idx;
    assign carrier     = r_carrier;
    assign busy        = w_active;
    assign period_done = r_period_done;

`ifdef SPWM_CTRL_COMPLEMENT_EN
    localparam int unsigned   DW       = $clog2(DEAD + 1) + 1;
    localparam logic [DW-1:0] DEAD_CNT = DW'(DEAD);

    logic [DW-1:0] r_hi_cnt, r_lo_cnt;
    logic          r_pwm_p, r_pwm_n;

    // Run-length counters saturate at DEAD; an output only rises once its run has outlasted DEAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi_cnt <= '0;
            r_lo_cnt <= '0;
            r_pwm_p  <= 1'b0;
            r_pwm_n  <= 1'b0;
        end else begin
            r_hi_cnt <= !r_raw ? '0 : (r_hi_cnt == DEAD_CNT) ? r_hi_cnt : r_hi_cnt + DW'(1);
            r_lo_cnt <= (r_raw || !w_active) ? '0 :
                        (r_lo_cnt == DEAD_CNT) ? r_lo_cnt : r_lo_cnt + DW'(1);
            r_pwm_p  <= r_raw && (r_hi_cnt >= DEAD_CNT);
            r_pwm_n  <= !r_raw && w_active && (r_lo_cnt >= DEAD_CNT);
        end
    end

    assign pwm_out = r_pwm_p;
    assign pwm_n   = r_pwm_n;
`else
    assign pwm_out = r_raw;
`endif

endmodule
